// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types for the SPI master
//
// Contents:
//   spi_state_t    : transfer sequencer states
//   spi_mode_t     : CPOL/CPHA pair captured at transfer start
//   is_sample_edge : selects whether an SCLK edge samples MISO or drives MOSI
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // With cpha=0 data is sampled on the leading edge; with cpha=1 on the
  // trailing edge. The other edge of each pair is the drive edge.
  function automatic logic is_sample_edge(input logic leading, input logic cpha);
    return leading ^ cpha;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for SCLK
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : count enable; the counter is held at zero while low
//   tick : one-cycle pulse on the last cycle of every CLK_DIV-cycle period
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  // A single-cycle divider still needs a one-bit counter to stay legal.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the first period after en rises is exactly CLK_DIV long.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-word SPI master, all CPOL/CPHA modes, MSB first
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   start             : transfer request, honoured only while idle
//   tx_data           : word to send, captured when start is accepted
//   cpol, cpha        : SPI mode, captured when start is accepted
//   rx_data           : last received word, updated with done
//   busy              : transfer in progress
//   done              : one-cycle pulse when the transfer finishes
//   sclk, ss, mosi    : SPI clock, active-low select, master-out data
//   miso              : master-in data (not synchronised here)
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [EW-1:0]     edge_cnt;
  logic              tick;
  logic              div_en;
  logic              leading;

  assign div_en = (state != IDLE);

  // Edges alternate leading/trailing starting with a leading edge at 0.
  assign leading = ~edge_cnt[0];

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Track the live polarity so the line already rests at the
          // right level when a transfer begins.
          sclk <= cpol;
          if (start) begin
            state       <= SETUP;
            mode_q.cpol <= cpol;
            mode_q.cpha <= cpha;
            ss          <= 1'b0;
            busy        <= 1'b1;
            edge_cnt    <= '0;
            rx_sh       <= '0;
            if (!cpha) begin
              // cpha=0 needs the MSB valid before the first leading edge.
              mosi  <= tx_data[DATA_W-1];
              tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
              mosi  <= 1'b0;
              tx_sh <= tx_data;
            end
          end
        end

        SETUP: begin
          sclk <= mode_q.cpol;
          if (tick) begin
            state <= XFER;
          end
        end

        XFER: begin
          if (tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (is_sample_edge(leading, mode_q.cpha)) begin
              rx_sh <= {rx_sh[DATA_W-2:0], miso};
            end else if (edge_cnt != LAST_EDGE) begin
              // The final trailing edge of cpha=0 has no further bit to send.
              mosi  <= tx_sh[DATA_W-1];
              tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
            if (edge_cnt == LAST_EDGE) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          sclk <= mode_q.cpol;
          if (tick) begin
            state   <= IDLE;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
